// File: rtl/branch_sequencer.sv
// rtl/branch_sequencer.sv - multi-cycle branch execute unit driving the datapath control word
module branch_sequencer #(
    parameter int DATA_WIDTH   = 64,
    parameter int LINK_REG     = 30,
    parameter int ZERO_REG     = 31,
    parameter int ENABLE_BCOND = 1
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [31:0]           I,
    input  logic [4:0]            status,
    output logic                  busy,
    output logic                  done,
    output logic                  illegal,
    output logic [32:0]           cw_IW,
    output logic [DATA_WIDTH-1:0] K
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LINK,
        S_TEST,
        S_BRANCH,
        S_BRANCH_REG,
        S_SKIP
    } state_t;

    localparam logic [4:0] ZERO_ADDR = 5'(ZERO_REG);
    localparam logic [4:0] LINK_ADDR = 5'(LINK_REG);
    localparam logic [4:0] FS_OR     = 5'b00100;
    localparam logic [4:0] FS_IDLE   = 5'b11111;

    state_t                  state, state_next;
    logic [DATA_WIDTH-1:0]   k_q;
    logic [4:0]              src_reg_q;
    logic                    cb_nz_q;
    logic                    illegal_q;

    logic is_b, is_bl, is_cbz, is_cbnz, is_bcond, is_br, legal, accept;
    logic [DATA_WIDTH-1:0]   imm_ext;

    // {N,Z,C,V} condition evaluation; odd codes invert the even test except AL/NV
    function automatic logic cond_holds(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cf, v, r;
        {n, z, cf, v} = f;
        case (c[3:1])
            3'b000:  r = z;
            3'b001:  r = cf;
            3'b010:  r = n;
            3'b011:  r = v;
            3'b100:  r = cf & ~z;
            3'b101:  r = (n == v);
            3'b110:  r = ~z & (n == v);
            default: r = 1'b1;
        endcase
        if (c[0] && (c[3:1] != 3'b111))
            r = ~r;
        return r;
    endfunction

    always_comb begin
        is_b     = (I[31:26] == 6'b000101);
        is_bl    = (I[31:26] == 6'b100101);
        is_cbz   = (I[31:24] == 8'b10110100);
        is_cbnz  = (I[31:24] == 8'b10110101);
        is_bcond = (I[31:24] == 8'b01010100) && (ENABLE_BCOND != 0);
        is_br    = (I[31:21] == 11'b11010110000);
        legal    = is_b | is_bl | is_cbz | is_cbnz | is_bcond | is_br;
        accept   = (state == S_IDLE) && start && legal;

        imm_ext = '0;
        if (is_b || is_bl)
            imm_ext = {{(DATA_WIDTH-26){I[25]}}, I[25:0]};
        else if (is_cbz || is_cbnz || is_bcond)
            imm_ext = {{(DATA_WIDTH-19){I[23]}}, I[23:5]};
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= S_IDLE;
            k_q       <= '0;
            src_reg_q <= ZERO_ADDR;
            cb_nz_q   <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state     <= state_next;
            illegal_q <= (state == S_IDLE) && start && !legal;
            if (accept) begin
                k_q       <= imm_ext;
                src_reg_q <= is_br ? I[9:5] : I[4:0];
                cb_nz_q   <= I[24];
            end
        end
    end

    logic       alu_en, alu_bs, rf_w, pc_en, pc_is;
    logic [4:0] alu_fs, rf_sa, rf_sb, rf_da;
    logic [1:0] pc_fs, next_st;

    always_comb begin
        state_next = state;
        alu_en     = 1'b0;
        alu_bs     = 1'b0;
        alu_fs     = FS_IDLE;
        rf_sa      = ZERO_ADDR;
        rf_sb      = ZERO_ADDR;
        rf_da      = ZERO_ADDR;
        rf_w       = 1'b0;
        pc_en      = 1'b0;
        pc_fs      = 2'b00;
        pc_is      = 1'b0;
        next_st    = 2'b00;
        done       = 1'b0;

        case (state)
            S_IDLE: begin
                if (accept) begin
                    if (is_b)
                        state_next = S_BRANCH;
                    else if (is_bl)
                        state_next = S_LINK;
                    else if (is_cbz || is_cbnz)
                        state_next = S_TEST;
                    else if (is_br)
                        state_next = S_BRANCH_REG;
                    else
                        state_next = cond_holds(I[3:0], status[3:0]) ? S_BRANCH : S_SKIP;
                end
            end
            S_LINK: begin
                pc_en      = 1'b1;
                rf_da      = LINK_ADDR;
                rf_w       = 1'b1;
                next_st    = 2'b11;
                state_next = S_BRANCH;
            end
            S_TEST: begin
                alu_fs     = FS_OR;
                rf_sa      = src_reg_q;
                next_st    = 2'b11;
                // live ALU zero flag decides taken: CBZ wants 1, CBNZ wants 0
                state_next = (cb_nz_q ^ status[4]) ? S_BRANCH : S_SKIP;
            end
            S_BRANCH: begin
                pc_fs      = 2'b11;
                pc_is      = 1'b1;
                done       = 1'b1;
                state_next = S_IDLE;
            end
            S_BRANCH_REG: begin
                alu_en     = 1'b1;
                alu_fs     = FS_OR;
                rf_sa      = src_reg_q;
                pc_fs      = 2'b10;
                done       = 1'b1;
                state_next = S_IDLE;
            end
            S_SKIP: begin
                pc_fs      = 2'b01;
                done       = 1'b1;
                state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    assign cw_IW   = {alu_en, alu_bs, alu_fs, 1'b0, rf_sa, rf_sb, rf_da, rf_w,
                      1'b0, 1'b0, pc_en, pc_fs, pc_is, 1'b0, next_st};
    assign busy    = (state != S_IDLE);
    assign illegal = illegal_q;
    assign K       = (state == S_IDLE) ? '0 : k_q;

endmodule

// File: tb/tb_branch_sequencer.sv
// tb/tb_branch_sequencer.sv - directed self-checking bench for branch_sequencer
module tb_branch_sequencer;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [31:0] I = '0;
    logic [4:0]  status = '0;
    logic        busy, done, illegal;
    logic [32:0] cw_IW;
    logic [63:0] K;

    int checks = 0;
    int errors = 0;

    branch_sequencer dut (
        .clock   (clock),
        .reset_n (reset_n),
        .start   (start),
        .I       (I),
        .status  (status),
        .busy    (busy),
        .done    (done),
        .illegal (illegal),
        .cw_IW   (cw_IW),
        .K       (K)
    );

    always #5 clock = ~clock;

    localparam logic [32:0] IDLE_WORD = 33'h07DFFFC00;

    function automatic logic [32:0] mk_cw(input logic alu_en, input logic [4:0] fs,
                                          input logic [4:0] sa, input logic [4:0] da,
                                          input logic rf_w, input logic pc_en,
                                          input logic [1:0] pc_fs, input logic pc_is,
                                          input logic [1:0] ns);
        return {alu_en, 1'b0, fs, 1'b0, sa, 5'd31, da, rf_w, 1'b0, 1'b0,
                pc_en, pc_fs, pc_is, 1'b0, ns};
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic issue(input logic [31:0] instr, input logic [4:0] st);
        I      = instr;
        status = st;
        start  = 1'b1;
        step();
        start  = 1'b0;
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_cw"},   64'(cw_IW), 64'(IDLE_WORD));
        check({tag, "_busy"}, 64'(busy), 64'd0);
        check({tag, "_done"}, 64'(done), 64'd0);
        check({tag, "_K"},    K, 64'd0);
    endtask

    logic [32:0] w_branch, w_skip, w_link, w_test5, w_br7;

    initial begin
        w_branch = mk_cw(1'b0, 5'h1F, 5'd31, 5'd31, 1'b0, 1'b0, 2'b11, 1'b1, 2'b00);
        w_skip   = mk_cw(1'b0, 5'h1F, 5'd31, 5'd31, 1'b0, 1'b0, 2'b01, 1'b0, 2'b00);
        w_link   = mk_cw(1'b0, 5'h1F, 5'd31, 5'd30, 1'b1, 1'b1, 2'b00, 1'b0, 2'b11);
        w_test5  = mk_cw(1'b0, 5'h04, 5'd5,  5'd31, 1'b0, 1'b0, 2'b00, 1'b0, 2'b11);
        w_br7    = mk_cw(1'b1, 5'h04, 5'd7,  5'd31, 1'b0, 1'b0, 2'b10, 1'b0, 2'b00);

        #1;
        check_idle("reset");
        check("reset_illegal", 64'(illegal), 64'd0);
        step();
        reset_n = 1'b1;
        step();
        check_idle("post_reset");

        // B with imm26 all ones
        issue({6'b000101, 26'h3FFFFFF}, 5'b0);
        check("b_K",    K, 64'hFFFF_FFFF_FFFF_FFFF);
        check("b_cw",   64'(cw_IW), 64'(w_branch));
        check("b_done", 64'(done), 64'd1);
        check("b_busy", 64'(busy), 64'd1);
        step();
        check_idle("b_after");

        // BL imm26 = 0x10
        issue({6'b100101, 26'h10}, 5'b0);
        check("bl_c1_cw",   64'(cw_IW), 64'(w_link));
        check("bl_c1_done", 64'(done), 64'd0);
        check("bl_c1_K",    K, 64'h10);
        step();
        check("bl_c2_cw",   64'(cw_IW), 64'(w_branch));
        check("bl_c2_done", 64'(done), 64'd1);
        check("bl_c2_K",    K, 64'h10);
        step();
        check_idle("bl_after");

        // CBZ Rt=5, negative imm19, zero flag set -> taken
        issue({8'b10110100, 19'h40000, 5'd5}, 5'b10000);
        check("cbz_test_cw", 64'(cw_IW), 64'(w_test5));
        check("cbz_K",       K, 64'hFFFF_FFFF_FFFC_0000);
        check("cbz_busy",    64'(busy), 64'd1);
        step();
        check("cbz_br_cw",   64'(cw_IW), 64'(w_branch));
        check("cbz_done",    64'(done), 64'd1);
        step();

        // CBNZ Rt=5 with zero flag set -> not taken
        issue({8'b10110101, 19'h2, 5'd5}, 5'b10000);
        check("cbnz_test_cw", 64'(cw_IW), 64'(w_test5));
        step();
        check("cbnz_skip_cw", 64'(cw_IW), 64'(w_skip));
        check("cbnz_done",    64'(done), 64'd1);
        step();

        // CBNZ with zero flag clear -> taken
        issue({8'b10110101, 19'h2, 5'd5}, 5'b00000);
        step();
        check("cbnz0_cw", 64'(cw_IW), 64'(w_branch));
        check("cbnz0_K",  K, 64'h2);
        step();

        // B.cond GT, flags all clear -> taken
        issue({8'b01010100, 19'h3, 5'b01100}, 5'b00000);
        check("gt0_cw",   64'(cw_IW), 64'(w_branch));
        check("gt0_K",    K, 64'h3);
        check("gt0_done", 64'(done), 64'd1);
        step();
        // GT with Z=1 -> skip
        issue({8'b01010100, 19'h3, 5'b01100}, 5'b00100);
        check("gtz_cw", 64'(cw_IW), 64'(w_skip));
        step();
        // LT with N=1 V=0 -> taken
        issue({8'b01010100, 19'h3, 5'b01011}, 5'b01000);
        check("lt_cw", 64'(cw_IW), 64'(w_branch));
        step();
        // EQ with Z=0 -> skip
        issue({8'b01010100, 19'h3, 5'b00000}, 5'b00000);
        check("eq_cw", 64'(cw_IW), 64'(w_skip));
        step();

        // BR Rn=7
        issue({11'b11010110000, 5'b11111, 6'b0, 5'd7, 5'd0}, 5'b0);
        check("br_cw",   64'(cw_IW), 64'(w_br7));
        check("br_done", 64'(done), 64'd1);
        check("br_K",    K, 64'd0);
        step();
        check_idle("br_after");

        // unrecognised opcode
        issue(32'h8B000000, 5'b0);
        check("ill_pulse", 64'(illegal), 64'd1);
        check("ill_busy",  64'(busy), 64'd0);
        check("ill_cw",    64'(cw_IW), 64'(IDLE_WORD));
        step();
        check("ill_clear", 64'(illegal), 64'd0);

        // start while busy is ignored
        issue({6'b100101, 26'h10}, 5'b0);
        I     = 32'h8B000000;
        start = 1'b1;
        step();
        start = 1'b0;
        check("busy_ign_ill",  64'(illegal), 64'd0);
        check("busy_ign_done", 64'(done), 64'd1);
        step();
        check("busy_ign_idle", 64'(busy), 64'd0);
        check("busy_ign_ill2", 64'(illegal), 64'd0);

        // reset during LINK
        issue({6'b100101, 26'h10}, 5'b0);
        check("rst_link_w", 64'(cw_IW[9]), 64'd1);
        reset_n = 1'b0;
        #1;
        check_idle("rst_async");
        step();
        check_idle("rst_held");
        reset_n = 1'b1;
        step();
        check_idle("rst_release");
        check("rst_illegal", 64'(illegal), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
